// File: rtl/i2c_sequencer.sv
// Register-transaction sequencer driving a byte-level I2C controller.
// Optional watchdog on controller handshakes: define I2C_SEQUENCER_TIMEOUT_EN.
module i2c_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  dev_address,
    input  logic [7:0]  reg_address,
    input  logic        is_read,
    input  logic [1:0]  length,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        seq_busy,
    output logic        nak,
    output logic        timeout,
    output logic        ctl_trigger,
    output logic        ctl_restart,
    output logic        ctl_last_byte,
    output logic        ctl_read_write,
    output logic [6:0]  ctl_address,
    output logic [7:0]  ctl_write_data,
    output logic        ctl_reset,
    input  logic        ctl_busy,
    input  logic        ctl_ack_error,
    input  logic [7:0]  ctl_read_data
);

    typedef enum logic [3:0] {
        IDLE, ADDR_W, REG, DATA_W, RESTART, ADDR_R, DATA_R, WAIT_HI, WAIT_LO, DONE
    } state_t;

    state_t      state_q, state_d;
    state_t      step_q, step_d;
    logic        armed_q, armed_d;
    logic        abort_q, abort_d;
    logic [1:0]  idx_q, idx_d;
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  reg_q, reg_d;
    logic        rd_q, rd_d;
    logic [1:0]  len_q, len_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        nak_q, nak_d;
    logic [6:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [7:0]  wdat_q, wdat_d;
    logic        last_q, last_d;
    logic        trig_q, trig_d;
    logic        restart_q, restart_d;
`ifdef I2C_SEQUENCER_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    logic        ctl_reset_q, ctl_reset_d;
`endif

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        armed_d   = armed_q;
        abort_d   = abort_q;
        idx_d     = idx_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        rd_d      = rd_q;
        len_d     = len_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        nak_d     = nak_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        wdat_d    = wdat_q;
        last_d    = last_q;
        trig_d    = 1'b0;
        restart_d = 1'b0;
`ifdef I2C_SEQUENCER_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = timeout_q;
        ctl_reset_d = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dev_d   = dev_address;
                    reg_d   = reg_address;
                    rd_d    = is_read;
                    len_d   = length;
                    wdata_d = wdata;
                    rdata_d = '0;
                    nak_d   = 1'b0;
                    idx_d   = '0;
                    abort_d = 1'b0;
                    armed_d = 1'b0;
`ifdef I2C_SEQUENCER_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d = ADDR_W;
                end
            end
            // Byte steps: first cycle loads the controller fields, second cycle fires the trigger.
            ADDR_W, REG, DATA_W, DATA_R: begin
                if (!armed_q) begin
                    armed_d = 1'b1;
                    wdat_d  = 8'h00;
                    last_d  = 1'b0;
                    rw_d    = (state_q == DATA_R);
                    if (state_q == ADDR_W) addr_d = dev_q;
                    if (state_q == REG) wdat_d = reg_q;
                    if (state_q == DATA_W && !abort_q) wdat_d = wdata_q[{idx_q, 3'b000} +: 8];
                    if (state_q == DATA_W || state_q == DATA_R) last_d = abort_q || (idx_q == len_q);
                end else begin
                    armed_d = 1'b0;
                    trig_d  = 1'b1;
                    step_d  = state_q;
                    state_d = WAIT_HI;
                end
            end
            RESTART: begin
                restart_d = 1'b1;
                addr_d    = dev_q;
                rw_d      = 1'b1;
                wdat_d    = 8'h00;
                last_d    = 1'b0;
                state_d   = ADDR_R;
            end
            ADDR_R: begin
                trig_d  = 1'b1;
                step_d  = ADDR_R;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (ctl_busy) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!ctl_busy) begin
                    // A NAK on any master-sent byte diverts into one STOP-only step.
                    if (step_q == DATA_W && abort_q) begin
                        state_d = DONE;
                    end else if (step_q != DATA_R && ctl_ack_error) begin
                        nak_d   = 1'b1;
                        abort_d = 1'b1;
                        state_d = DATA_W;
                    end else begin
                        unique case (step_q)
                            ADDR_W:  state_d = REG;
                            REG:     state_d = rd_q ? RESTART : DATA_W;
                            ADDR_R:  state_d = DATA_R;
                            DATA_W, DATA_R: begin
                                if (step_q == DATA_R) rdata_d[{idx_q, 3'b000} +: 8] = ctl_read_data;
                                if (idx_q == len_q) begin
                                    state_d = DONE;
                                end else begin
                                    idx_d   = idx_q + 2'd1;
                                    state_d = step_q;
                                end
                            end
                            default: state_d = DONE;
                        endcase
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef I2C_SEQUENCER_TIMEOUT_EN
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == WAIT_HI || state_q == WAIT_LO) begin
            if (cnt_q == 16'hFFFF) begin
                timeout_d   = 1'b1;
                ctl_reset_d = 1'b1;
                state_d     = DONE;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            step_q    <= IDLE;
            armed_q   <= 1'b0;
            abort_q   <= 1'b0;
            idx_q     <= '0;
            dev_q     <= '0;
            reg_q     <= '0;
            rd_q      <= 1'b0;
            len_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            nak_q     <= 1'b0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            wdat_q    <= '0;
            last_q    <= 1'b0;
            trig_q    <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            armed_q   <= armed_d;
            abort_q   <= abort_d;
            idx_q     <= idx_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            rd_q      <= rd_d;
            len_q     <= len_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            nak_q     <= nak_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            wdat_q    <= wdat_d;
            last_q    <= last_d;
            trig_q    <= trig_d;
            restart_q <= restart_d;
        end
    end

`ifdef I2C_SEQUENCER_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            ctl_reset_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            ctl_reset_q <= ctl_reset_d;
        end
    end

    assign timeout   = timeout_q;
    assign ctl_reset = ctl_reset_q;
`else
    assign timeout   = 1'b0;
    assign ctl_reset = 1'b0;
`endif

    // done is decoded from DONE so a new start can only be seen the cycle after.
    assign done           = (state_q == DONE);
    assign seq_busy       = (state_q != IDLE) && (state_q != DONE);
    assign rdata          = rdata_q;
    assign nak            = nak_q;
    assign ctl_trigger    = trig_q;
    assign ctl_restart    = restart_q;
    assign ctl_last_byte  = last_q;
    assign ctl_read_write = rw_q;
    assign ctl_address    = addr_q;
    assign ctl_write_data = wdat_q;

endmodule

// File: tb/tb_i2c_sequencer.sv
// Scoreboard bench for i2c_sequencer: a controller model answers triggers, a monitor
// pops expected trigger fields and completion results as the DUT presents them.
`timescale 1ns/1ps
module tb_i2c_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  dev_address = '0;
    logic [7:0]  reg_address = '0;
    logic        is_read = 1'b0;
    logic [1:0]  length = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        done, seq_busy, nak, timeout;
    logic        ctl_trigger, ctl_restart, ctl_last_byte, ctl_read_write, ctl_reset;
    logic [6:0]  ctl_address;
    logic [7:0]  ctl_write_data;
    logic        ctl_busy, ctl_ack_error;
    logic [7:0]  ctl_read_data;

    i2c_sequencer dut (
        .clock(clock), .reset(reset), .start(start),
        .dev_address(dev_address), .reg_address(reg_address), .is_read(is_read),
        .length(length), .wdata(wdata), .rdata(rdata), .done(done),
        .seq_busy(seq_busy), .nak(nak), .timeout(timeout),
        .ctl_trigger(ctl_trigger), .ctl_restart(ctl_restart), .ctl_last_byte(ctl_last_byte),
        .ctl_read_write(ctl_read_write), .ctl_address(ctl_address),
        .ctl_write_data(ctl_write_data), .ctl_reset(ctl_reset),
        .ctl_busy(ctl_busy), .ctl_ack_error(ctl_ack_error), .ctl_read_data(ctl_read_data)
    );

    always #5 clock = ~clock;

    typedef struct { logic [6:0] addr; logic rw; logic [7:0] wd; logic last; logic rs; } trig_t;
    typedef struct { logic [31:0] rdata; logic nak; logic tmo; } done_t;
    typedef struct { logic [7:0] rd; logic ack; } resp_t;

    trig_t exp_trig[$];
    done_t exp_done[$];
    resp_t resp_q[$];

    int n_tests = 0, n_fail = 0;
    int trig_cnt = 0, done_cnt = 0, rst_pulse_cnt = 0;
    bit saw_restart = 1'b0, hold_chk_en = 1'b1, stuck_busy = 1'b0;
    logic [16:0] prev_f = '0, held_f = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_trig(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                             input logic last, input logic rs);
        trig_t t;
        t.addr = a; t.rw = rw; t.wd = wd; t.last = last; t.rs = rs;
        exp_trig.push_back(t);
    endtask

    task automatic push_resp(input logic [7:0] rd, input logic ack);
        resp_t r;
        r.rd = rd; r.ack = ack;
        resp_q.push_back(r);
    endtask

    task automatic push_done(input logic [31:0] rd, input logic nk, input logic tm);
        done_t d;
        d.rdata = rd; d.nak = nk; d.tmo = tm;
        exp_done.push_back(d);
    endtask

    task automatic issue(input logic [6:0] dv, input logic [7:0] rg, input logic rd,
                         input logic [1:0] ln, input logic [31:0] wd);
        @(negedge clock);
        start = 1'b1; dev_address = dv; reg_address = rg; is_read = rd; length = ln; wdata = wd;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, input string name);
        int c = 0;
        while (done_cnt == base && c < budget) begin
            @(negedge clock); #1; c++;
        end
        n_tests++;
        if (done_cnt == base) begin
            n_fail++;
            $display("FAIL %s: no done within %0d cycles", name, budget);
        end
    endtask

    task automatic settle();
        int c = 0;
        while ((ctl_busy || seq_busy) && c < 500) begin
            @(negedge clock); #1; c++;
        end
        repeat (3) @(negedge clock);
        #1;
    endtask

    task automatic check_zero(input string p);
        check({p, "_done"}, done, 0);
        check({p, "_seq_busy"}, seq_busy, 0);
        check({p, "_nak"}, nak, 0);
        check({p, "_timeout"}, timeout, 0);
        check({p, "_rdata"}, rdata, 0);
        check({p, "_trigger"}, ctl_trigger, 0);
        check({p, "_restart"}, ctl_restart, 0);
        check({p, "_last"}, ctl_last_byte, 0);
        check({p, "_rw"}, ctl_read_write, 0);
        check({p, "_address"}, ctl_address, 0);
        check({p, "_write_data"}, ctl_write_data, 0);
        check({p, "_ctl_reset"}, ctl_reset, 0);
    endtask

    // Controller model: busy rises the cycle after a trigger and falls three cycles later.
    initial begin
        resp_t r;
        ctl_busy = 1'b0; ctl_ack_error = 1'b0; ctl_read_data = '0;
        forever begin
            @(negedge clock);
            if (ctl_trigger && !reset) begin
                if (resp_q.size() > 0) r = resp_q.pop_front();
                else begin r.rd = 8'h00; r.ack = 1'b0; end
                ctl_ack_error = 1'b0;
                @(negedge clock);
                ctl_busy = 1'b1;
                repeat (3) @(negedge clock);
                while (stuck_busy) @(negedge clock);
                ctl_read_data = r.rd;
                ctl_ack_error = r.ack;
                ctl_busy = 1'b0;
            end
        end
    end

    // Monitor: compares every trigger and every done against the scoreboard queues.
    initial begin
        trig_t et;
        done_t ed;
        logic [16:0] cur;
        forever begin
            @(negedge clock);
            cur = {ctl_address, ctl_read_write, ctl_write_data, ctl_last_byte};
            if (reset) begin
                saw_restart = 1'b0;
            end else begin
                if (ctl_restart) saw_restart = 1'b1;
                if (ctl_reset) rst_pulse_cnt++;
                if (ctl_trigger) begin
                    trig_cnt++;
                    if (exp_trig.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_trigger: got addr 0x%0h data 0x%0h, expected none",
                                 ctl_address, ctl_write_data);
                    end else begin
                        et = exp_trig.pop_front();
                        check("trig_address", ctl_address, et.addr);
                        check("trig_read_write", ctl_read_write, et.rw);
                        check("trig_write_data", ctl_write_data, et.wd);
                        check("trig_last_byte", ctl_last_byte, et.last);
                        check("trig_restart_before", saw_restart, et.rs);
                        check("trig_setup_stable", cur, prev_f);
                    end
                    saw_restart = 1'b0;
                    held_f = cur;
                end else if (hold_chk_en && ctl_busy) begin
                    check("fields_held_while_busy", cur, held_f);
                end
                if (done) begin
                    done_cnt++;
                    if (exp_done.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_done: got rdata 0x%0h, expected no done", rdata);
                    end else begin
                        ed = exp_done.pop_front();
                        check("done_rdata", rdata, ed.rdata);
                        check("done_nak", nak, ed.nak);
                        check("done_timeout", timeout, ed.tmo);
                        check("done_seq_busy", seq_busy, 0);
                    end
                end
                prev_f = cur;
            end
        end
    end

    initial begin
        #2_000_000;
        n_tests++; n_fail++;
        $display("FAIL global_watchdog: bench time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int base, bt, rb;

        repeat (3) @(negedge clock);
        check_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;

        // Single-byte write.
        push_trig(7'h50, 0, 8'h00, 0, 0); push_trig(7'h50, 0, 8'h10, 0, 0); push_trig(7'h50, 0, 8'hA5, 1, 0);
        repeat (3) push_resp(8'h00, 0);
        push_done(32'h0, 0, 0);
        base = done_cnt;
        issue(7'h50, 8'h10, 0, 2'd0, 32'h0000_00A5);
        wait_done(base, 300, "write_1byte");
        settle();

        // Three-byte read with repeated start.
        push_trig(7'h68, 0, 8'h00, 0, 0); push_trig(7'h68, 0, 8'h00, 0, 0); push_trig(7'h68, 1, 8'h00, 0, 1);
        push_trig(7'h68, 1, 8'h00, 0, 0); push_trig(7'h68, 1, 8'h00, 0, 0); push_trig(7'h68, 1, 8'h00, 1, 0);
        repeat (3) push_resp(8'h00, 0);
        push_resp(8'h11, 0); push_resp(8'h22, 0); push_resp(8'h33, 0);
        push_done(32'h0033_2211, 0, 0);
        base = done_cnt;
        issue(7'h68, 8'h00, 1, 2'd2, 32'h0);
        wait_done(base, 500, "read_3byte");
        settle();

        // Address NAK: one STOP step, no data bytes.
        push_trig(7'h2A, 0, 8'h00, 0, 0); push_trig(7'h2A, 0, 8'h00, 1, 0);
        push_resp(8'h00, 1); push_resp(8'h00, 0);
        push_done(32'h0, 1, 0);
        base = done_cnt;
        issue(7'h2A, 8'h33, 0, 2'd1, 32'h0000_BEEF);
        wait_done(base, 300, "addr_nak");
        settle();
        check("nak_sticky_after_done", nak, 1);

        // Four-byte write with a start pulse mid-transaction; nak cleared by the new start.
        push_trig(7'h11, 0, 8'h00, 0, 0); push_trig(7'h11, 0, 8'h22, 0, 0);
        push_trig(7'h11, 0, 8'h11, 0, 0); push_trig(7'h11, 0, 8'h22, 0, 0);
        push_trig(7'h11, 0, 8'h33, 0, 0); push_trig(7'h11, 0, 8'h44, 1, 0);
        repeat (6) push_resp(8'h00, 0);
        push_done(32'h0, 0, 0);
        base = done_cnt;
        issue(7'h11, 8'h22, 0, 2'd3, 32'h4433_2211);
        repeat (4) @(negedge clock);
        issue(7'h7F, 8'hEE, 1, 2'd0, 32'hFFFF_FFFF);
        wait_done(base, 600, "write_4byte");
        repeat (30) @(negedge clock);
        #1;
        check("single_done", done_cnt, base + 1);
        check("trig_queue_drained", exp_trig.size(), 0);
        settle();

        // Read: NAK on the read address after repeated start.
        push_trig(7'h3C, 0, 8'h00, 0, 0); push_trig(7'h3C, 0, 8'h05, 0, 0);
        push_trig(7'h3C, 1, 8'h00, 0, 1); push_trig(7'h3C, 0, 8'h00, 1, 0);
        push_resp(8'h00, 0); push_resp(8'h00, 0); push_resp(8'h00, 1); push_resp(8'h00, 0);
        push_done(32'h0, 1, 0);
        base = done_cnt;
        issue(7'h3C, 8'h05, 1, 2'd0, 32'h0);
        wait_done(base, 400, "read_addr_nak");
        settle();

        // Maximum-length read.
        push_trig(7'h55, 0, 8'h00, 0, 0); push_trig(7'h55, 0, 8'hFE, 0, 0); push_trig(7'h55, 1, 8'h00, 0, 1);
        push_trig(7'h55, 1, 8'h00, 0, 0); push_trig(7'h55, 1, 8'h00, 0, 0);
        push_trig(7'h55, 1, 8'h00, 0, 0); push_trig(7'h55, 1, 8'h00, 1, 0);
        repeat (3) push_resp(8'h00, 0);
        push_resp(8'hDE, 0); push_resp(8'hAD, 0); push_resp(8'hBE, 0); push_resp(8'hEF, 0);
        push_done(32'hEFBE_ADDE, 0, 0);
        base = done_cnt;
        issue(7'h55, 8'hFE, 1, 2'd3, 32'h0);
        wait_done(base, 600, "read_4byte");
        settle();

        // Reset while in DATA_W: abort at once, no done, no further triggers.
        push_trig(7'h12, 0, 8'h00, 0, 0); push_trig(7'h12, 0, 8'h34, 0, 0);
        repeat (2) push_resp(8'h00, 0);
        base = done_cnt;
        bt = trig_cnt;
        issue(7'h12, 8'h34, 0, 2'd3, 32'hCAFE_F00D);
        begin
            int c = 0;
            while ((trig_cnt < bt + 2 || ctl_busy) && c < 300) begin
                @(negedge clock); #1; c++;
            end
            n_tests++;
            if (c == 300) begin
                n_fail++;
                $display("FAIL reset_setup: second step not completed, got %0d triggers", trig_cnt - bt);
            end
        end
        @(posedge clock);
        #1;
        hold_chk_en = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check_zero("midreset");
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        #1;
        check("midreset_no_done", done_cnt, base);
        check("midreset_no_more_triggers", trig_cnt, bt + 2);
        exp_trig.delete();
        resp_q.delete();
        hold_chk_en = 1'b1;
        settle();

        // Controller stuck busy.
        stuck_busy = 1'b1;
        rb = rst_pulse_cnt;
        base = done_cnt;
        push_trig(7'h01, 0, 8'h00, 0, 0);
`ifdef I2C_SEQUENCER_TIMEOUT_EN
        push_done(32'h0, 0, 1);
        issue(7'h01, 8'h02, 0, 2'd0, 32'h99);
        wait_done(base, 70000, "stuck_timeout");
        check("ctl_reset_pulses", rst_pulse_cnt, rb + 1);
        check("timeout_sticky", timeout, 1);
        stuck_busy = 1'b0;
        settle();
`else
        issue(7'h01, 8'h02, 0, 2'd0, 32'h99);
        repeat (300) @(negedge clock);
        #1;
        check("stuck_seq_busy", seq_busy, 1);
        check("stuck_no_ctl_reset", rst_pulse_cnt, rb);
        check("stuck_no_done", done_cnt, base);
        check("stuck_timeout_low", timeout, 0);
        hold_chk_en = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        stuck_busy = 1'b0;
        settle();
        hold_chk_en = 1'b1;
        check("stuck_cleared_by_reset", seq_busy, 0);
`endif

        check("final_trig_queue", exp_trig.size(), 0);
        check("final_done_queue", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_sequencer.md
I2C_SEQUENCER -- requirements
Module: i2c_sequencer

Interface
REQ-001 SHALL have port: clock  in  1  master clock, all logic on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
REQ-003 SHALL have port: start  in  1  one-cycle request to run a register transaction; sampled only in IDLE.
REQ-004 SHALL have port: dev_address  in  7  slave address, latched on accepted start.
REQ-005 SHALL have port: reg_address  in  8  register index, latched on accepted start.
REQ-006 SHALL have port: is_read  in  1  0=register write, 1=register read, latched on start.
REQ-007 SHALL have port: length  in  2  data byte count minus one (0..3 = 1..4 bytes), latched on start.
REQ-008 SHALL have port: wdata  in  32  write bytes, byte i = wdata[8i+7:8i], byte 0 sent first, latched on start.
REQ-009 SHALL have ports: rdata out 32 read bytes (same mapping as wdata, unread bytes 0); done out 1 one-cycle completion pulse; seq_busy out 1 high from accepted start until done; nak out 1 sticky ACK error; timeout out 1 sticky watchdog error.
REQ-010 SHALL have controller-side ports: ctl_trigger, ctl_restart, ctl_last_byte, ctl_read_write out 1; ctl_address out 7; ctl_write_data out 8; ctl_reset out 1; ctl_busy, ctl_ack_error in 1; ctl_read_data in 8.

Function
REQ-011 Write transaction SHALL issue: START+{dev,W}, reg_address, data bytes 0..length, STOP.
REQ-012 Read transaction SHALL issue: START+{dev,W}, reg_address, repeated START, {dev,R}, read bytes 0..length, STOP.
REQ-013 States SHALL be IDLE, ADDR_W, REG, DATA_W, RESTART, ADDR_R, DATA_R, WAIT_HI, WAIT_LO, DONE; WAIT_HI/WAIT_LO SHALL return to a stored next state.
REQ-014 Each controller step SHALL set ctl_address/ctl_read_write/ctl_write_data/ctl_last_byte at least one cycle before a one-cycle ctl_trigger, hold them until ctl_busy falls, then enter WAIT_HI (until ctl_busy=1) and WAIT_LO (until ctl_busy=0).
REQ-015 ctl_last_byte SHALL be 1 only on the final data byte step; 0 on address and register steps.
REQ-016 RESTART SHALL pulse ctl_restart one cycle, then the following cycle trigger with ctl_read_write=1.
REQ-017 After each byte step in write phases, ctl_ack_error SHALL be sampled on WAIT_LO exit; if 1, nak SHALL set and one extra step with ctl_write_data=0x00, ctl_last_byte=1 SHALL generate STOP, then DONE.
REQ-018 In DATA_R, ctl_read_data SHALL be stored to rdata byte i on WAIT_LO exit of step i.
REQ-019 DONE SHALL pulse done one cycle, clear seq_busy, return to IDLE; nak/timeout hold until next accepted start, which clears them and rdata.
REQ-020 start while not IDLE SHALL be ignored with no effect.
REQ-021 start and done in same cycle cannot occur; start is accepted no earlier than the cycle after DONE.

Reset
REQ-022 On reset: state IDLE; all outputs 0 (ctl_write_data=0x00, ctl_address=0, rdata=0); nak, timeout cleared.
REQ-023 Reset mid-transaction SHALL abort immediately without generating STOP; no done pulse.

Configuration
REQ-024 Macro I2C_SEQUENCER_TIMEOUT_EN defined: a 16-bit counter SHALL run in WAIT_HI/WAIT_LO, cleared on entry; at 0xFFFF it SHALL set timeout, pulse ctl_reset one cycle, go to DONE.
REQ-025 Macro undefined: no counter, timeout and ctl_reset tied 0, waits unbounded.

Verification
REQ-026 Write dev=0x50 reg=0x10 length=0 wdata=0xA5 -> 3 triggers, write_data 0x10 then 0xA5, last_byte on 3rd only, done, nak=0.
REQ-027 Read dev=0x68 reg=0x00 length=2, model returns 0x11,0x22,0x33 -> 1 restart pulse, read_write=1 on 3rd trigger, rdata=0x00332211, done.
REQ-028 Model NAKs address -> nak=1, one extra trigger with last_byte=1, write_data=0x00, done; no data bytes sent.
REQ-029 start asserted during a transaction -> ignored; latched fields unchanged; single done.
REQ-030 With I2C_SEQUENCER_TIMEOUT_EN, ctl_busy stuck high -> ctl_reset pulse after 65535 cycles, timeout=1, done; without macro -> no pulse, seq_busy stays 1.
REQ-031 Reset asserted mid DATA_W -> next cycle all outputs 0, state IDLE, no done.
